bram_master: RTL and testbench

- Initiator end of the BRAM ready/valid memory interface.
- Accepts one CPU-side load/store request: byte, half or word, signed or unsigned, any byte alignment.
- Turns it into one or two word-wide transactions on the BRAM port, with per-byte write enables.
- Returns an aligned, extended result (or a store acknowledge) on a response channel. Sits between the core's load/store stage and the BRAM responder.

---
 rtl/bram_master_if.sv | 54 +++++
 rtl/bram_master.sv | 198 +++++++++++++++++++
 tb/tb_bram_master.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_master_if.sv
// bram_master_if: groups the CPU request/response channels and the BRAM port.
//   master modport : the view of bram_master (drives o_*, samples i_*).
//   slave  modport : the opposite view (CPU stage + BRAM responder).
// Signals:
//   i_req_valid/o_req_ready, i_req_write, i_req_addr, i_req_size,
//   i_req_unsigned, i_req_wdata       - CPU request channel
//   o_resp_valid/i_resp_ready, o_resp_rdata
//                                      - CPU response channel
//   o_mem_addr, o_mem_data, o_mem_wr_valid/i_mem_wr_ready,
//   o_mem_byte_write_enable, o_mem_rd_ready, i_mem_data, i_mem_rd_valid
//                                      - BRAM port
interface bram_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                      i_req_valid;
    logic                      o_req_ready;
    logic                      i_req_write;
    logic [31:0]               i_req_addr;
    logic [1:0]                i_req_size;
    logic                      i_req_unsigned;
    logic [DATA_WIDTH-1:0]     i_req_wdata;

    logic                      o_resp_valid;
    logic                      i_resp_ready;
    logic [DATA_WIDTH-1:0]     o_resp_rdata;

    logic [ADDR_WIDTH-1:0]     o_mem_addr;
    logic [DATA_WIDTH-1:0]     o_mem_data;
    logic                      o_mem_wr_valid;
    logic                      i_mem_wr_ready;
    logic [DATA_WIDTH/8-1:0]   o_mem_byte_write_enable;
    logic                      o_mem_rd_ready;
    logic [DATA_WIDTH-1:0]     i_mem_data;
    logic                      i_mem_rd_valid;

    modport master (
        input  i_req_valid, i_req_write, i_req_addr, i_req_size,
               i_req_unsigned, i_req_wdata, i_resp_ready,
               i_mem_wr_ready, i_mem_data, i_mem_rd_valid,
        output o_req_ready, o_resp_valid, o_resp_rdata,
               o_mem_addr, o_mem_data, o_mem_wr_valid,
               o_mem_byte_write_enable, o_mem_rd_ready
    );

    modport slave (
        output i_req_valid, i_req_write, i_req_addr, i_req_size,
               i_req_unsigned, i_req_wdata, i_resp_ready,
               i_mem_wr_ready, i_mem_data, i_mem_rd_valid,
        input  o_req_ready, o_resp_valid, o_resp_rdata,
               o_mem_addr, o_mem_data, o_mem_wr_valid,
               o_mem_byte_write_enable, o_mem_rd_ready
    );
endinterface

// File: rtl/bram_master.sv
// bram_master: initiator end of the BRAM ready/valid memory interface.
// Takes one byte/half/word load or store at any byte alignment, issues one or
// two word transactions (two when the access straddles a word boundary),
// and returns an aligned, sign/zero-extended load result or a store ack.
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low reset
//   bus      - bram_master_if.master (request, response and BRAM channels)
module bram_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    bram_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP} state_t;

    state_t                state_q, state_d;
    logic                  write_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] lo_addr_q;
    logic [7:0]            lanes_q;     // byte lanes across the {hi,lo} word pair
    logic [DATA_WIDTH-1:0] lo_buf_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  ready_c;
    logic                  accept;
    logic                  lo_cap;
    logic                  rdata_load;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [3:0]            size_mask;
    logic [7:0]            req_lanes;
    logic [63:0]           wr_wide;
    logic [ADDR_WIDTH-1:0] hi_addr;
    logic                  split;

    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_data_c;
    logic [3:0]            mem_be_c;
    logic                  mem_wr_valid_c;
    logic                  mem_rd_ready_c;
    logic                  resp_valid_c;

    // Address bits above the BRAM word range are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.i_req_addr[31:ADDR_WIDTH+2];

    // Shift the {hi,lo} pair down by the byte offset and extend from the
    // top bit of the accessed size.
    function automatic logic [31:0] extract(input logic [63:0] pair,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = 32'(pair >> {off, 3'b000});
        case (size)
            2'd0:    res = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    res = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    always_comb begin
        case (bus.i_req_size)
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign req_lanes = {4'b0000, size_mask} << bus.i_req_addr[1:0];
    assign split     = |lanes_q[7:4];
    assign hi_addr   = lo_addr_q + ADDR_WIDTH'(1);
    // Low half of the shifted word feeds the lo beat, high half the hi beat.
    assign wr_wide   = {32'b0, wdata_q} << {off_q, 3'b000};
    assign accept    = ready_c & bus.i_req_valid;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        ready_c        = 1'b0;
        lo_cap         = 1'b0;
        rdata_load     = 1'b0;
        rdata_d        = '0;
        mem_addr_c     = '0;
        mem_data_c     = '0;
        mem_be_c       = '0;
        mem_wr_valid_c = 1'b0;
        mem_rd_ready_c = 1'b0;
        resp_valid_c   = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.i_req_valid) state_d = bus.i_req_write ? WR_LO : RD_LO;
            end
            RD_LO: begin
                mem_rd_ready_c = 1'b1;
                mem_addr_c     = lo_addr_q;
                if (bus.i_mem_rd_valid) begin
                    lo_cap = 1'b1;
                    if (split) begin
                        state_d = RD_HI;
                    end else begin
                        state_d    = RESP;
                        rdata_load = 1'b1;
                        rdata_d    = extract({32'b0, bus.i_mem_data}, off_q, size_q, unsigned_q);
                    end
                end
            end
            RD_HI: begin
                mem_rd_ready_c = 1'b1;
                mem_addr_c     = hi_addr;
                if (bus.i_mem_rd_valid) begin
                    state_d    = RESP;
                    rdata_load = 1'b1;
                    rdata_d    = extract({bus.i_mem_data, lo_buf_q}, off_q, size_q, unsigned_q);
                end
            end
            WR_LO: begin
                mem_wr_valid_c = 1'b1;
                mem_addr_c     = lo_addr_q;
                mem_data_c     = wr_wide[31:0];
                mem_be_c       = lanes_q[3:0];
                if (bus.i_mem_wr_ready) begin
                    state_d    = split ? WR_HI : RESP;
                    rdata_load = !split;
                end
            end
            WR_HI: begin
                mem_wr_valid_c = 1'b1;
                mem_addr_c     = hi_addr;
                mem_data_c     = wr_wide[63:32];
                mem_be_c       = lanes_q[7:4];
                if (bus.i_mem_wr_ready) begin
                    state_d    = RESP;
                    rdata_load = 1'b1;
                end
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.i_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the datapath registers are few and reset alongside the FSM, so the
    // response word reads 0 out of reset rather than stale data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            lo_addr_q  <= '0;
            lanes_q    <= '0;
            lo_buf_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q    <= bus.i_req_write;
                off_q      <= bus.i_req_addr[1:0];
                size_q     <= bus.i_req_size;
                unsigned_q <= bus.i_req_unsigned;
                wdata_q    <= bus.i_req_wdata;
                lo_addr_q  <= bus.i_req_addr[ADDR_WIDTH+1:2];
                lanes_q    <= req_lanes;
            end
            if (lo_cap)     lo_buf_q <= bus.i_mem_data;
            if (rdata_load) rdata_q  <= write_q ? '0 : rdata_d;
        end
    end

    // IDLE is also the reset state, so ready is masked by reset directly to
    // keep it low while i_rst_n is held.
    assign bus.o_req_ready             = ready_c & i_rst_n;
    assign bus.o_resp_valid            = resp_valid_c;
    assign bus.o_resp_rdata            = rdata_q;
    assign bus.o_mem_addr              = mem_addr_c;
    assign bus.o_mem_data              = mem_data_c;
    assign bus.o_mem_wr_valid          = mem_wr_valid_c;
    assign bus.o_mem_byte_write_enable = mem_be_c;
    assign bus.o_mem_rd_ready          = mem_rd_ready_c;

endmodule

// File: tb/tb_bram_master.sv
// tb_bram_master: directed bench for bram_master with a BRAM responder model
// (write accepted same cycle, read word returned one cycle after rd_ready)
// and a response scoreboard.
module tb_bram_master;

    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    always #5 clk = ~clk;

    bram_master_if bus ();

    bram_master dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // ---------------- BRAM responder model ----------------
    typedef struct {
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    logic [31:0] mem [1024];
    logic        rd_valid_r = 1'b0;
    logic [31:0] rd_data_r;
    beat_t       wr_log[$];
    logic [9:0]  rd_log[$];

    assign bus.i_mem_wr_ready = bus.o_mem_wr_valid;
    assign bus.i_mem_rd_valid = rd_valid_r;
    assign bus.i_mem_data     = rd_data_r;

    always @(posedge clk) begin
        rd_valid_r <= bus.o_mem_rd_ready && !rd_valid_r;
        rd_data_r  <= mem[bus.o_mem_addr];
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h44332211;
            mem[1] <= 32'h88776655;
        end else if (bus.o_mem_wr_valid) begin
            for (int b = 0; b < 4; b++)
                if (bus.o_mem_byte_write_enable[b])
                    mem[bus.o_mem_addr][8*b +: 8] <= bus.o_mem_data[8*b +: 8];
            wr_log.push_back('{bus.o_mem_addr, bus.o_mem_byte_write_enable, bus.o_mem_data});
        end
        if (bus.o_mem_rd_ready && rd_valid_r) rd_log.push_back(bus.o_mem_addr);
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         input bit push, input logic [31:0] exp_rdata, input int exp_lat);
        @(negedge clk);
        bus.i_req_write    = wr;
        bus.i_req_addr     = addr;
        bus.i_req_size     = size;
        bus.i_req_unsigned = uns;
        bus.i_req_wdata    = wdata;
        bus.i_req_valid    = 1'b1;
        check("req_ready_idle", 32'(bus.o_req_ready), 32'd1);
        if (push) exp_q.push_back('{exp_rdata, exp_lat});
        @(posedge clk);
        #1;
        // Fields are registered at accept; scramble them afterwards.
        bus.i_req_valid    = 1'b0;
        bus.i_req_write    = 1'($urandom);
        bus.i_req_addr     = $urandom;
        bus.i_req_size     = 2'($urandom);
        bus.i_req_unsigned = 1'($urandom);
        bus.i_req_wdata    = $urandom;
    endtask

    // Called #1 after the accept edge; counts cycles to the response, then
    // holds i_resp_ready low for 'hold' cycles before consuming it.
    task automatic await_resp(input string tag, input int hold);
        int          n;
        bit          got;
        exp_t        e;
        logic [31:0] first;
        n   = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            if (bus.o_resp_valid) got = 1;
        end
        check({tag, "_resp_seen"}, 32'(got), 32'd1);
        if (!got) return;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(n), 32'(e.lat));
        check({tag, "_rdata"}, bus.o_resp_rdata, e.rdata);
        first = bus.o_resp_rdata;
        for (int h = 0; h < hold; h++) begin
            if (h > 0) @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.o_resp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.o_resp_rdata, first);
            check({tag, "_hold_req_ready"}, 32'(bus.o_req_ready), 32'd0);
            check({tag, "_hold_mem_idle"},
                  32'({bus.o_mem_wr_valid, bus.o_mem_rd_ready}), 32'd0);
        end
        bus.i_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_resp_drop"}, 32'(bus.o_resp_valid), 32'd0);
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [9:0] a,
                              input logic [3:0] be, input logic [31:0] d);
        check({tag, "_present"}, 32'(wr_log.size() > idx), 32'd1);
        if (wr_log.size() <= idx) return;
        check({tag, "_addr"}, 32'(wr_log[idx].addr), 32'(a));
        check({tag, "_be"}, 32'(wr_log[idx].be), 32'(be));
        check({tag, "_data"}, wr_log[idx].data, d);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, 32'(bus.o_req_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(bus.o_resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, bus.o_resp_rdata, 32'd0);
        check({tag, "_mem_ctl"}, 32'({bus.o_mem_wr_valid, bus.o_mem_rd_ready,
                                      bus.o_mem_byte_write_enable}), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.o_mem_addr), 32'd0);
        check({tag, "_mem_data"}, bus.o_mem_data, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  rb;
        int  wb;
        bit  found;
        bus.i_req_valid    = 1'b0;
        bus.i_req_write    = 1'b0;
        bus.i_req_addr     = '0;
        bus.i_req_size     = '0;
        bus.i_req_unsigned = 1'b0;
        bus.i_req_wdata    = '0;
        bus.i_resp_ready   = 1'b1;
        preload = 1'b1;
        rst_n   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        preload = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(bus.o_req_ready), 32'd1);

        // LW 0x0: aligned, one read of word 0.
        rb = rd_log.size();
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1, 32'h44332211, 3);
        await_resp("lw0", 0);
        check("lw0_rd_count", 32'(rd_log.size() - rb), 32'd1);
        if (rd_log.size() > rb) check("lw0_rd_addr", 32'(rd_log[rb]), 32'd0);

        // LHU 0x3: split across words 0 and 1.
        rb = rd_log.size();
        issue(1'b0, 32'h3, 2'd1, 1'b1, 32'h0, 1, 32'h00005544, 5);
        await_resp("lhu3", 0);
        check("lhu3_rd_count", 32'(rd_log.size() - rb), 32'd2);
        if (rd_log.size() > rb + 1) begin
            check("lhu3_rd_lo", 32'(rd_log[rb]), 32'd0);
            check("lhu3_rd_hi", 32'(rd_log[rb+1]), 32'd1);
        end

        // Byte / half sign handling and size 3 treated as word.
        issue(1'b0, 32'h7, 2'd0, 1'b0, 32'h0, 1, 32'hFFFFFF88, 3);
        await_resp("lb7", 0);
        issue(1'b0, 32'h7, 2'd0, 1'b1, 32'h0, 1, 32'h00000088, 3);
        await_resp("lbu7", 0);
        issue(1'b0, 32'h6, 2'd1, 1'b0, 32'h0, 1, 32'hFFFF8877, 3);
        await_resp("lh6", 0);
        issue(1'b0, 32'h2, 2'd1, 1'b0, 32'h0, 1, 32'h00004433, 3);
        await_resp("lh2", 0);
        issue(1'b0, 32'hFFFF_F004, 2'd3, 1'b0, 32'h0, 1, 32'h88776655, 3);
        await_resp("lw_size3", 0);

        // Asynchronous reset while in RD_HI of a split load.
        issue(1'b0, 32'h3, 2'd1, 1'b1, 32'h0, 0, 32'h0, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.o_mem_rd_ready && bus.o_mem_addr == 10'd1) found = 1;
        end
        check("rdhi_reached", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 1, 32'h88776655, 3);
        await_resp("lw4_after_reset", 0);

        // SW 0xDEADBEEF at 0x2: split store.
        wb = wr_log.size();
        issue(1'b1, 32'h2, 2'd2, 1'b0, 32'hDEADBEEF, 1, 32'h0, 3);
        await_resp("sw2", 0);
        check("sw2_beats", 32'(wr_log.size() - wb), 32'd2);
        check_beat("sw2_b1", wb, 10'd0, 4'b1100, 32'hBEEF0000);
        check_beat("sw2_b2", wb + 1, 10'd1, 4'b0011, 32'h0000DEAD);
        check("sw2_word0", mem[0], 32'hBEEF2211);
        check("sw2_word1", mem[1], 32'h8877DEAD);
        issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1, 32'hBEEF2211, 3);
        await_resp("lw0_after_sw", 0);

        // SB 0x5A at 0x9: aligned store latency 2.
        wb = wr_log.size();
        issue(1'b1, 32'h9, 2'd0, 1'b0, 32'h1234565A, 1, 32'h0, 2);
        await_resp("sb9", 0);
        check("sb9_beats", 32'(wr_log.size() - wb), 32'd1);
        check_beat("sb9_b1", wb, 10'd2, 4'b0010, 32'h34565A00);
        check("sb9_word2", mem[2], 32'h00005A00);

        // SH 0xCAFE at 0xFFF: wraps to word 0, response held 3 cycles.
        wb = wr_log.size();
        bus.i_resp_ready = 1'b0;
        issue(1'b1, 32'hFFF, 2'd1, 1'b0, 32'h0000CAFE, 1, 32'h0, 3);
        await_resp("sh_wrap", 3);
        check("sh_wrap_beats", 32'(wr_log.size() - wb), 32'd2);
        check_beat("sh_wrap_b1", wb, 10'd1023, 4'b1000, 32'hFE000000);
        check_beat("sh_wrap_b2", wb + 1, 10'd0, 4'b0001, 32'h000000CA);
        check("sh_wrap_word1023", mem[1023], 32'hFE000000);
        check("sh_wrap_word0", mem[0], 32'hBEEF22CA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
